main_fsm: RTL and testbench

Multicycle RV32I main control state machine. It sequences fetch, decode, execute, memory and writeback for one instruction at a time. It drives the datapath mux selects and write enables, and produces the 2-bit `aluop` consumed by the ALU decoder, which turns `aluop`/`funct3`/`funct7b5` into the 4-bit ALU control. It sits in the controller beside that decoder and the branch logic, and stalls on a memory ready handshake.

---
 rtl/main_fsm_if.sv | 33 +++
 rtl/main_fsm.sv | 148 ++++++++++++++
 tb/tb_main_fsm.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/main_fsm_if.sv
// Control bundle between the multicycle RV32I main FSM and its datapath/memory side.
// The master modport is the FSM; the slave modport is the datapath it steers.
interface main_fsm_if #(
    parameter int INSTRET_W = 32
);
    logic [6:0]           op;
    logic                 mem_ready;
    logic [1:0]           aluop;
    logic [1:0]           alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           resultsrc;
    logic                 adrsrc;
    logic                 irwrite;
    logic                 pcupdate;
    logic                 branch;
    logic                 regwrite;
    logic                 memwrite;
    logic                 illegal;
    logic [INSTRET_W-1:0] instret;
    logic [3:0]           state;

    modport master (
        input  op, mem_ready,
        output aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcupdate,
               branch, regwrite, memwrite, illegal, instret, state
    );

    modport slave (
        output op, mem_ready,
        input  aluop, alusrca, alusrcb, resultsrc, adrsrc, irwrite, pcupdate,
               branch, regwrite, memwrite, illegal, instret, state
    );
endinterface

// File: rtl/main_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Define MAIN_FSM_UPPER_IMM_EN to add the LUI and AUIPC execute states.
module main_fsm #(
    parameter int INSTRET_W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    main_fsm_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_AUIPC    = 4'd12,
        S_ERROR    = 4'd15
    } state_t;

    state_t               state_reg;
    state_t               state_next;
    logic [INSTRET_W-1:0] instret_reg;
    logic                 retire;

    // An instruction retires on any edge that lands in FETCH from a non-FETCH state.
    assign retire = (state_next == S_FETCH) && (state_reg != S_FETCH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= S_FETCH;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire)
                instret_reg <= instret_reg + INSTRET_W'(1);
        end
    end

    assign bus.state   = state_reg;
    assign bus.instret = instret_reg;
    assign bus.illegal = (state_reg == S_ERROR);

    always_comb begin
        state_next    = S_ERROR;
        bus.aluop     = 2'b00;
        bus.alusrca   = 2'b00;
        bus.alusrcb   = 2'b00;
        bus.resultsrc = 2'b00;
        bus.adrsrc    = 1'b0;
        bus.irwrite   = 1'b0;
        bus.pcupdate  = 1'b0;
        bus.branch    = 1'b0;
        bus.regwrite  = 1'b0;
        bus.memwrite  = 1'b0;
        unique case (state_reg)
            S_FETCH: begin
                bus.alusrcb   = 2'b10;
                bus.resultsrc = 2'b10;
                bus.irwrite   = bus.mem_ready;
                bus.pcupdate  = bus.mem_ready;
                state_next    = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
                case (bus.op)
                    7'b0000011,
                    7'b0100011: state_next = S_MEMADR;
                    7'b0110011: state_next = S_EXECR;
                    7'b0010011: state_next = S_EXECI;
                    7'b1100011: state_next = S_BRANCH;
                    7'b1101111: state_next = S_JAL;
`ifdef MAIN_FSM_UPPER_IMM_EN
                    7'b0110111: state_next = S_LUI;
                    7'b0010111: state_next = S_AUIPC;
`endif
                    default:    state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                state_next  = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adrsrc = 1'b1;
                state_next = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                bus.resultsrc = 2'b01;
                bus.regwrite  = 1'b1;
                state_next    = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adrsrc   = 1'b1;
                bus.memwrite = 1'b1;
                state_next   = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                bus.alusrca = 2'b10;
                bus.aluop   = 2'b10;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                bus.alusrca = 2'b10;
                bus.alusrcb = 2'b01;
                bus.aluop   = 2'b10;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                bus.regwrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca = 2'b10;
                bus.aluop   = 2'b01;
                bus.branch  = 1'b1;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                bus.alusrca  = 2'b01;
                bus.alusrcb  = 2'b10;
                bus.pcupdate = 1'b1;
                state_next   = S_ALUWB;
            end
`ifdef MAIN_FSM_UPPER_IMM_EN
            S_LUI: begin
                bus.alusrca = 2'b11;
                bus.alusrcb = 2'b01;
                state_next  = S_ALUWB;
            end
            S_AUIPC: begin
                bus.alusrca = 2'b01;
                bus.alusrcb = 2'b01;
                state_next  = S_ALUWB;
            end
`endif
            default: state_next = S_ERROR;
        endcase
    end
endmodule

// File: tb/tb_main_fsm.sv
// Directed testbench for main_fsm: walks each instruction class, stalls, ERROR and reset.
module tb_main_fsm;
    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    main_fsm_if #(.INSTRET_W(32)) bus ();

    main_fsm #(.INSTRET_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        reset_n       = 1'b0;
        bus.mem_ready = 1'b1;
        bus.op        = 7'b0110011;

        // Reset lands in FETCH with FETCH outputs
        go();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_aluop", 32'(bus.aluop), 0);
        chk("rst_alusrcb", 32'(bus.alusrcb), 2);
        chk("rst_resultsrc", 32'(bus.resultsrc), 2);
        chk("rst_irwrite", 32'(bus.irwrite), 1);
        chk("rst_pcupdate", 32'(bus.pcupdate), 1);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_instret", bus.instret, 0);
        reset_n = 1'b1;

        // R-type: 0,1,6,8,0
        go();
        chk("r_dec_state", 32'(bus.state), 1);
        chk("r_dec_alusrca", 32'(bus.alusrca), 1);
        chk("r_dec_alusrcb", 32'(bus.alusrcb), 1);
        go();
        chk("r_exec_state", 32'(bus.state), 6);
        chk("r_exec_aluop", 32'(bus.aluop), 2);
        chk("r_exec_alusrca", 32'(bus.alusrca), 2);
        chk("r_exec_regwrite", 32'(bus.regwrite), 0);
        go();
        chk("r_wb_state", 32'(bus.state), 8);
        chk("r_wb_regwrite", 32'(bus.regwrite), 1);
        chk("r_wb_instret", bus.instret, 0);
        go();
        chk("r_fetch_state", 32'(bus.state), 0);
        chk("r_fetch_regwrite", 32'(bus.regwrite), 0);
        chk("r_instret", bus.instret, 1);

        // lw with two stall cycles in MEMREAD: 7 cycles
        bus.op = 7'b0000011;
        go();
        chk("lw_dec_state", 32'(bus.state), 1);
        go();
        chk("lw_adr_state", 32'(bus.state), 2);
        chk("lw_adr_alusrca", 32'(bus.alusrca), 2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go();
            if (i == 2) bus.mem_ready = 1'b1;
            #1;
            chk("lw_rd_state", 32'(bus.state), 3);
            chk("lw_rd_adrsrc", 32'(bus.adrsrc), 1);
            chk("lw_rd_regwrite", 32'(bus.regwrite), 0);
        end
        go();
        chk("lw_wb_state", 32'(bus.state), 4);
        chk("lw_wb_regwrite", 32'(bus.regwrite), 1);
        chk("lw_wb_resultsrc", 32'(bus.resultsrc), 1);
        go();
        chk("lw_fetch_state", 32'(bus.state), 0);
        chk("lw_instret", bus.instret, 2);

        // sw with three stall cycles in MEMWRITE
        bus.op = 7'b0100011;
        go();
        chk("sw_dec_state", 32'(bus.state), 1);
        go();
        chk("sw_adr_state", 32'(bus.state), 2);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            go();
            if (i == 3) bus.mem_ready = 1'b1;
            #1;
            chk("sw_wr_state", 32'(bus.state), 5);
            chk("sw_wr_memwrite", 32'(bus.memwrite), 1);
            chk("sw_wr_regwrite", 32'(bus.regwrite), 0);
            chk("sw_wr_instret", bus.instret, 2);
        end
        go();
        chk("sw_fetch_state", 32'(bus.state), 0);
        chk("sw_fetch_memwrite", 32'(bus.memwrite), 0);
        chk("sw_instret", bus.instret, 3);

        // beq: 0,1,9,0
        bus.op = 7'b1100011;
        go();
        chk("beq_dec_branch", 32'(bus.branch), 0);
        go();
        chk("beq_state", 32'(bus.state), 9);
        chk("beq_aluop", 32'(bus.aluop), 1);
        chk("beq_branch", 32'(bus.branch), 1);
        go();
        chk("beq_fetch_state", 32'(bus.state), 0);
        chk("beq_fetch_branch", 32'(bus.branch), 0);
        chk("beq_instret", bus.instret, 4);

        // FETCH stall: no advance, no irwrite, no retire
        bus.mem_ready = 1'b0;
        #1;
        chk("fstall_irwrite", 32'(bus.irwrite), 0);
        chk("fstall_pcupdate", 32'(bus.pcupdate), 0);
        go();
        chk("fstall_state", 32'(bus.state), 0);
        chk("fstall_instret", bus.instret, 4);
        bus.mem_ready = 1'b1;

        // jal: 0,1,10,8,0
        bus.op = 7'b1101111;
        go();
        go();
        chk("jal_state", 32'(bus.state), 10);
        chk("jal_pcupdate", 32'(bus.pcupdate), 1);
        chk("jal_alusrcb", 32'(bus.alusrcb), 2);
        go();
        chk("jal_wb_state", 32'(bus.state), 8);
        chk("jal_wb_pcupdate", 32'(bus.pcupdate), 0);
        go();
        chk("jal_instret", bus.instret, 5);

        // I-type ALU: 0,1,7,8,0
        bus.op = 7'b0010011;
        go();
        go();
        chk("iop_state", 32'(bus.state), 7);
        chk("iop_aluop", 32'(bus.aluop), 2);
        chk("iop_alusrcb", 32'(bus.alusrcb), 1);
        go();
        go();
        chk("iop_fetch_state", 32'(bus.state), 0);
        chk("iop_instret", bus.instret, 6);

        // Unsupported opcode: sticky ERROR, instret frozen, mem_ready ignored
        bus.op = 7'b1110011;
        go();
        for (int i = 0; i < 10; i++) begin
            go();
            bus.mem_ready = 1'(i % 2);
            #1;
            chk("err_state", 32'(bus.state), 15);
            chk("err_illegal", 32'(bus.illegal), 1);
            chk("err_regwrite", 32'(bus.regwrite), 0);
            chk("err_instret", bus.instret, 6);
        end
        bus.mem_ready = 1'b1;
        reset_n       = 1'b0;
        go();
        reset_n = 1'b1;
        chk("err_rst_state", 32'(bus.state), 0);
        chk("err_rst_illegal", 32'(bus.illegal), 0);
        chk("err_rst_instret", bus.instret, 0);

        // lui: dispatch depends on build option
        bus.op = 7'b0110111;
        go();
        go();
`ifdef MAIN_FSM_UPPER_IMM_EN
        chk("lui_state", 32'(bus.state), 11);
        chk("lui_alusrca", 32'(bus.alusrca), 3);
        chk("lui_alusrcb", 32'(bus.alusrcb), 1);
        go();
        chk("lui_wb_state", 32'(bus.state), 8);
        go();
        chk("lui_instret", bus.instret, 1);
`else
        chk("lui_state", 32'(bus.state), 15);
        chk("lui_illegal", 32'(bus.illegal), 1);
        reset_n = 1'b0;
        go();
        reset_n = 1'b1;
        chk("lui_rst_state", 32'(bus.state), 0);
`endif

        // Reset asserted mid-instruction in MEMADR
        bus.op = 7'b0000011;
        go();
        go();
        chk("midrst_adr_state", 32'(bus.state), 2);
        reset_n = 1'b0;
        go();
        reset_n = 1'b1;
        chk("midrst_state", 32'(bus.state), 0);
        chk("midrst_instret", bus.instret, 0);
        chk("midrst_irwrite", 32'(bus.irwrite), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
